// File: rtl/lzw_pkg.sv
// LZW output buffer shared definitions: cipher constants,
// capture FSM state type and the inverse-transform helper.
package lzw_pkg;

    localparam logic [7:0] LZW_KEY    = 8'h3C;
    localparam logic [7:0] LZW_OFFSET = 8'h05;

    typedef enum logic {
        CAP_IDLE,
        CAP_HOLD
    } cap_state_t;

    // Undo the compressor transform: (b - OFFSET) ^ KEY, 8-bit wrap.
    function automatic logic [7:0] lzw_decode(input logic [7:0] b);
        return (b - LZW_OFFSET) ^ LZW_KEY;
    endfunction

endpackage

// File: rtl/lzw_sync_fifo.sv
// Single-clock FIFO for the LZW output buffer.
// Ports: i_push/i_pop/i_wdata in; o_head_next (head byte as it will
// be after the current edge), o_level, o_full, o_empty out.
module lzw_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_head_next,
    output logic [AW:0]   o_level,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;

    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_rd_next;
    logic [AW:0]   w_level_next;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

    // A push into a full FIFO only lands when a pop frees a slot
    // on the same edge.
    assign w_push = i_push && (!o_full || i_pop);
    assign w_pop  = i_pop && !o_empty;

    assign w_rd_next = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

    always_comb begin
        w_level_next = r_level;
        unique case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + (AW+1)'(1);
            2'b01:   w_level_next = r_level - (AW+1)'(1);
            default: w_level_next = r_level;
        endcase
    end

    // The next head is the incoming byte when it is written into the
    // slot that becomes the head (FIFO empty after this edge's pop).
    always_comb begin
        o_head_next = r_mem[w_rd_next];
        if (w_push && (r_wr_ptr == w_rd_next)) begin
            o_head_next = i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_level  <= w_level_next;
        end
    end

endmodule

// File: rtl/lzw_output_buffer.sv
// LZW output buffer: captures a byte per comp_done rising edge, buffers
// it and streams it out on out_valid/out_ready; overflow is sticky.
// Ports: clk, rst_n (async low), comp_data/comp_done in; out_data,
// out_valid, level, overflow out; out_ready in.
// Option: LZW_DECODE_CHECK_EN presents the decoded source byte.
module lzw_output_buffer
    import lzw_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    comp_data,
    input  logic          comp_done,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic          overflow
);

    cap_state_t  r_state;
    cap_state_t  w_state_nxt;
    logic        w_capture;

    logic        r_overflow;
    logic [7:0]  r_out_data;

    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_head_next;
    logic [7:0]  w_out_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CAP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Only the first cycle of a held done level captures.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        unique case (r_state)
            CAP_IDLE: begin
                if (comp_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = CAP_HOLD;
                end
            end
            CAP_HOLD: begin
                if (!comp_done) begin
                    w_state_nxt = CAP_IDLE;
                end
            end
            default: w_state_nxt = CAP_IDLE;
        endcase
    end

    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;

    lzw_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (8),
        .AW    (AW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_capture),
        .i_pop       (w_pop),
        .i_wdata     (comp_data),
        .o_head_next (w_head_next),
        .o_level     (level),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

`ifdef LZW_DECODE_CHECK_EN
    assign w_out_next = lzw_decode(w_head_next);
`else
    assign w_out_next = w_head_next;
`endif

    // out_data is a true register fed with the post-edge head, so it
    // tracks the FIFO head with no extra latency and holds on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            r_out_data <= w_out_next;
            if (w_capture && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_data = r_out_data;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_lzw_output_buffer.sv
// Self-checking bench for lzw_output_buffer: directed vector table plus
// sequences for reset, full push+pop and random back-pressure.
module tb_lzw_output_buffer;

    logic       clk;
    logic       rst_n;
    logic [7:0] comp_data;
    logic       comp_done;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    lzw_output_buffer #(.DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .comp_data (comp_data),
        .comp_done (comp_done),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ex(input logic [7:0] b);
`ifdef LZW_DECODE_CHECK_EN
        logic [7:0] t;
        t = b - 8'h05;
        return t ^ 8'h3C;
`else
        return b;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One pulse: done high one cycle, low one cycle. Starts/ends at negedge.
    task automatic pulse(input logic [7:0] d, input logic rdy);
        comp_data = d;
        comp_done = 1'b1;
        out_ready = rdy;
        @(negedge clk);
        comp_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic       done;
        logic [7:0] data;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] el;
        logic       eo;
    } vec_t;

    vec_t tbl[22];

    logic [7:0] q[$];
    logic [7:0] prev_d;
    bit         prev_stall;
    bit         do_push;
    bit         pop;
    bit         full;
    int         sent;
    int         drops;

    initial begin
        tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 8'h3D, 1'b1, 1'b1, 8'h3D, 3'd1, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[3]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 8'hA0, 3'd1, 1'b0};
        tbl[4]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 8'hA0, 3'd1, 1'b0};
        tbl[5]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 8'hA0, 3'd1, 1'b0};
        tbl[6]  = '{1'b0, 8'hA0, 1'b0, 1'b1, 8'hA0, 3'd1, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[8]  = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 3'd1, 1'b0};
        tbl[9]  = '{1'b0, 8'h01, 1'b0, 1'b1, 8'h01, 3'd1, 1'b0};
        tbl[10] = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 3'd2, 1'b0};
        tbl[11] = '{1'b0, 8'h02, 1'b0, 1'b1, 8'h01, 3'd2, 1'b0};
        tbl[12] = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 3'd3, 1'b0};
        tbl[13] = '{1'b0, 8'h03, 1'b0, 1'b1, 8'h01, 3'd3, 1'b0};
        tbl[14] = '{1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 3'd4, 1'b0};
        tbl[15] = '{1'b0, 8'h04, 1'b0, 1'b1, 8'h01, 3'd4, 1'b0};
        tbl[16] = '{1'b1, 8'h05, 1'b0, 1'b1, 8'h01, 3'd4, 1'b1};
        tbl[17] = '{1'b0, 8'h05, 1'b1, 1'b1, 8'h02, 3'd3, 1'b1};
        tbl[18] = '{1'b0, 8'h05, 1'b1, 1'b1, 8'h03, 3'd2, 1'b1};
        tbl[19] = '{1'b0, 8'h05, 1'b1, 1'b1, 8'h04, 3'd1, 1'b1};
        tbl[20] = '{1'b0, 8'h05, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1};
        tbl[21] = '{1'b0, 8'h05, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1};

        rst_n     = 1'b0;
        comp_done = 1'b0;
        comp_data = 8'h00;
        out_ready = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", out_data, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte, held done, fill/overflow and drain.
        for (int i = 0; i < 22; i++) begin
            comp_done = tbl[i].done;
            comp_data = tbl[i].data;
            out_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("v%0d_level", i), level, tbl[i].el);
            chk($sformatf("v%0d_ovf", i), overflow, tbl[i].eo);
            if (tbl[i].ev)
                chk($sformatf("v%0d_data", i), out_data, ex(tbl[i].ed));
            @(negedge clk);
        end

        // Asynchronous reset mid-stream, away from any clock edge.
        pulse(8'h11, 1'b0);
        pulse(8'h22, 1'b0);
        chk("pre_rst_level", level, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_data", out_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full FIFO with push and pop on the same edge.
        pulse(8'hAA, 1'b0);
        pulse(8'hBB, 1'b0);
        pulse(8'hCC, 1'b0);
        pulse(8'hDD, 1'b0);
        chk("fpp_full", level, 4);
        comp_data = 8'h77;
        comp_done = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("fpp_level", level, 4);
        chk("fpp_ovf", overflow, 0);
        chk("fpp_d0", out_data, ex(8'hBB));
        @(negedge clk);
        comp_done = 1'b0;
        @(posedge clk);
        #1;
        chk("fpp_d1", out_data, ex(8'hCC));
        chk("fpp_l1", level, 3);
        @(posedge clk);
        #1;
        chk("fpp_d2", out_data, ex(8'hDD));
        @(posedge clk);
        #1;
        chk("fpp_d3", out_data, ex(8'h77));
        chk("fpp_l3", level, 1);
        @(posedge clk);
        #1;
        chk("fpp_empty", out_valid, 0);
        chk("fpp_ovf_end", overflow, 0);
        @(negedge clk);

        // Random back-pressure against a queue model.
        out_ready = 1'b0;
        do_reset();
        q.delete();
        sent = 0;
        drops = 0;
        prev_stall = 1'b0;
        prev_d = 8'h00;
        for (int c = 0; c < 120; c++) begin
            chk("bp_valid", out_valid, q.size() != 0);
            chk("bp_level", level, q.size());
            if (q.size() != 0)
                chk("bp_data", out_data, ex(q[0]));
            if (prev_stall)
                chk("bp_stall", out_data, prev_d);
            do_push = (c % 2 == 0) && (sent < 32);
            comp_done = do_push;
            comp_data = 8'($urandom);
            out_ready = (c >= 64) ? 1'b1 : ($urandom_range(0, 3) != 0);
            pop = (q.size() != 0) && out_ready;
            full = (q.size() == 4);
            prev_stall = (q.size() != 0) && !out_ready;
            prev_d = out_data;
            if (pop)
                void'(q.pop_front());
            if (do_push) begin
                sent++;
                if (!full || pop)
                    q.push_back(comp_data);
                else
                    drops++;
            end
            @(negedge clk);
        end
        chk("bp_sent", sent, 32);
        chk("bp_drain_level", level, 0);
        chk("bp_drain_valid", out_valid, 0);
        chk("bp_ovf", overflow, drops != 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
